// File: rtl/yoda_pkg.sv
// Shared image geometry, offset widths and the sweeper state type used by
// the mask offset sweeper and its per-axis step logic.
package yoda_pkg;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int ROW_W = 8;
  localparam int COL_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_UPDATE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/mask_offset_sweeper_axis.sv
// Combinational next offset / direction for one mask axis.
// Bounces between 0 and MAX by default; MASK_SWEEP_WRAP_EN selects wrap-around.
module offset_axis_step #(
  parameter int W    = 9,
  parameter int STEP = 4,
  parameter int MAX  = 256
) (
  input  logic [W-1:0] off,
  input  logic         dir,
  output logic [W-1:0] next_off,
  output logic         next_dir
);

  // One extra bit of headroom so off+STEP never overflows.
  localparam logic [W:0] STEP_X = (W+1)'(STEP);
  localparam logic [W:0] MAX_X  = (W+1)'(MAX);

  logic [W:0] sum_s;
  logic [W:0] diff_s;

`ifdef MASK_SWEEP_WRAP_EN
  logic unused_dir_s;
  assign unused_dir_s = dir;

  // Wrap: overshoot past MAX re-enters from 0.
  always_comb begin
    sum_s    = {1'b0, off} + STEP_X;
    diff_s   = sum_s - MAX_X - (W+1)'(1);
    next_dir = 1'b0;
    if (sum_s > MAX_X) begin
      next_off = diff_s[W-1:0];
    end else begin
      next_off = sum_s[W-1:0];
    end
  end
`else
  // Bounce: clamp at either limit and reverse direction there.
  always_comb begin
    sum_s    = {1'b0, off} + STEP_X;
    diff_s   = {1'b0, off} - STEP_X;
    next_off = off;
    next_dir = dir;
    if (dir == 1'b0) begin
      if (sum_s >= MAX_X) begin
        next_off = MAX_X[W-1:0];
        next_dir = 1'b1;
      end else begin
        next_off = sum_s[W-1:0];
        next_dir = 1'b0;
      end
    end else begin
      if ({1'b0, off} <= STEP_X) begin
        next_off = {W{1'b0}};
        next_dir = 1'b0;
      end else begin
        next_off = diff_s[W-1:0];
        next_dir = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mask_offset_sweeper.sv
// Moves the image mask once every FRAMES_PER_STEP frames, changing offsets only
// at frame boundaries. Build option: MASK_SWEEP_WRAP_EN (wrap instead of bounce).
module mask_offset_sweeper
  import yoda_pkg::*;
#(
  parameter int MASK_W          = 64,
  parameter int MASK_H          = 48,
  parameter int STEP_COL        = 4,
  parameter int STEP_ROW        = 2,
  parameter int FRAMES_PER_STEP = 1,
  parameter int START_COL       = 0,
  parameter int START_ROW       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_done,
  input  logic             recenter,
  output logic [ROW_W-1:0] mask_row_offset,
  output logic [COL_W-1:0] mask_col_offset,
  output logic             offset_update,
  output logic             dir_row,
  output logic             dir_col
);

  localparam int MAX_COL = IMG_W - MASK_W;
  localparam int MAX_ROW = IMG_H - MASK_H;
  localparam logic [7:0]       CNT_LAST    = 8'(FRAMES_PER_STEP - 1);
  localparam logic [COL_W-1:0] START_COL_X = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] START_ROW_X = ROW_W'(START_ROW);

  sweep_state_e     state_r, state_s;
  logic [7:0]       cnt_r, cnt_s;
  logic             pending_r, pending_s;
  logic             load_step_s, load_start_s;
  logic [COL_W-1:0] col_r, col_next_s;
  logic [ROW_W-1:0] row_r, row_next_s;
  logic             dir_col_r, dir_col_next_s;
  logic             dir_row_r, dir_row_next_s;
  logic             update_r;

  offset_axis_step #(.W(COL_W), .STEP(STEP_COL), .MAX(MAX_COL)) u_col_step (
    .off      (col_r),
    .dir      (dir_col_r),
    .next_off (col_next_s),
    .next_dir (dir_col_next_s)
  );

  offset_axis_step #(.W(ROW_W), .STEP(STEP_ROW), .MAX(MAX_ROW)) u_row_step (
    .off      (row_r),
    .dir      (dir_row_r),
    .next_off (row_next_s),
    .next_dir (dir_row_next_s)
  );

  // Next-state, frame counter and load selection.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    load_step_s  = 1'b0;
    load_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s        = 8'd0;
        load_start_s = pending_r;
        if (enable) begin
          state_s = ST_COUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end else if (frame_done) begin
          if (cnt_r == CNT_LAST) begin
            state_s = ST_UPDATE;
            cnt_s   = 8'd0;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_UPDATE: begin
        // A recenter pending or arriving now replaces the step.
        if (pending_r || recenter) begin
          load_start_s = 1'b1;
        end else begin
          load_step_s = 1'b1;
        end
        if (enable) begin
          state_s = ST_COUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Recenter request flag: cleared when applied unless a fresh request lands outside UPDATE.
  always_comb begin
    if (load_start_s) begin
      pending_s = recenter && (state_r != ST_UPDATE);
    end else begin
      pending_s = pending_r | recenter;
    end
  end

  // State, counter, flag and registered offset outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      pending_r <= 1'b0;
      col_r     <= START_COL_X;
      row_r     <= START_ROW_X;
      dir_col_r <= 1'b0;
      dir_row_r <= 1'b0;
      update_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pending_r <= pending_s;
      update_r  <= load_start_s | load_step_s;
      if (load_start_s) begin
        col_r     <= START_COL_X;
        row_r     <= START_ROW_X;
        dir_col_r <= 1'b0;
        dir_row_r <= 1'b0;
      end else if (load_step_s) begin
        col_r     <= col_next_s;
        row_r     <= row_next_s;
        dir_col_r <= dir_col_next_s;
        dir_row_r <= dir_row_next_s;
      end else begin
        col_r     <= col_r;
        row_r     <= row_r;
        dir_col_r <= dir_col_r;
        dir_row_r <= dir_row_r;
      end
    end
  end

  assign mask_col_offset = col_r;
  assign mask_row_offset = row_r;
  assign dir_col         = dir_col_r;
  assign dir_row         = dir_row_r;
  assign offset_update   = update_r;

endmodule
